pipelined_cla_alu: RTL
======================

Name: pipelined_cla_alu

Overview:
- Parametrised, two-stage pipelined carry-lookahead adder/subtractor with a valid/ready handshake. It is the next generation of the team's 32-bit combinational CLA.
- Adds generic width and block size, add/sub/carry-chained ops, signed and unsigned compare flags, and a tag passthrough.
- Sits between the decode/operand-read stage and the execute writeback in the processor datapath, and also serves the multi-cycle multiplier for partial-sum accumulation.

Parameters:
- WIDTH, 32: operand/result width; must be a multiple of BLOCK.
- BLOCK, 8: lookahead block size in bits; NBLK = WIDTH/BLOCK, with 2 <= NBLK <= 16.
- TAG_W, 4: width of the opaque tag carried alongside each operation.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation present.
- in_ready  out  1  block can accept this cycle.
- op  in  2  00 ADD, 01 SUB, 10 ADDC, 11 SUBB.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only by ADDC/SUBB.
- tag_in  in  TAG_W  opaque tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- result  out  WIDTH  sum/difference.
- cout  out  1  carry out of the MSB.
- ovf  out  1  signed overflow.
- lt  out  1  signed A<B (valid for SUB/SUBB).
- ltu  out  1  unsigned A<B (valid for SUB/SUBB).
- ne  out  1  result nonzero.
- tag_out  out  TAG_W  tag of the result.

Behaviour:
- Operand prep:
  - b' = b for ADD/ADDC; b' = ~b for SUB/SUBB.
  - c0 = 0 (ADD), 1 (SUB), cin (ADDC), cin (SUBB).
  - For SUBB, cin=1 means "no borrow".
- Stage 1 (register S1), one cycle:
  - Each BLOCK slice produces block generate G[i] and propagate P[i].
  - Each slice also produces two sums, sum0[i] (carry-in 0) and sum1[i] (carry-in 1).
  - S1 latches sum0, sum1, G, P, c0, a[MSB], b'[MSB], op, tag.
- Stage 2 (register S2), one cycle:
  - Block carries are computed with full two-level lookahead: c[i+1] = G[i] | P[i]&c[i], flattened to AND-OR terms, with no ripple across blocks.
  - result block i = c[i] ? sum1[i] : sum0[i]; cout = c[NBLK].
- Flags, registered in S2:
  - ovf = (a_msb == b'_msb) & (result_msb != a_msb).
  - lt = result_msb ^ ovf.
  - ltu = ~cout.
  - ne = OR-reduce(result).
  - lt and ltu are computed for all ops but are meaningful only for SUB/SUBB.
- Latency: exactly 2 cycles from accept (in_valid & in_ready) to out_valid with no stall. Throughput is 1 op/cycle.
- Handshake:
  - v1 and v2 are the stage valid bits.
  - adv2 = ~v2 | out_ready.
  - adv1 = ~v1 | adv2.
  - in_ready = adv1 (combinational from out_ready; no skid buffer).
  - S2 loads when adv2, taking v2 <= v1. S1 loads when adv1, taking v1 <= in_valid.
  - Bubbles collapse: an empty S2 accepts S1 even when out_ready=0.
  - While out_valid & ~out_ready, all outputs hold stable.
  - Data registers of an invalid stage are don't-care but must not produce X on the flag outputs.
- Ordering: strictly in order; tag_out equals the tag_in of the same op.
- Reset, asynchronous and active low:
  - v1=v2=0; out_valid=0; result=0; cout=ovf=lt=ltu=ne=0; tag_out=0.
  - in_ready=1 once reset_n is high.
  - Reset asserted mid-operation drops all in-flight ops; none reappear after release.
- Simultaneous events: accept and emit in the same cycle are legal when out_ready=1 and both stages are full. The pipeline shifts and no op is lost or duplicated.
- Wrap-around: ADD/ADDC wrap modulo 2^WIDTH; cout reports the carry.

Decomposition:
- Shared package alu_pkg holds:
  - op encodings (OP_ADD, OP_SUB, OP_ADDC, OP_SUBB);
  - a flags struct {cout, ovf, lt, ltu, ne};
  - a function for NBLK.
- One sub-module, cla_block: a BLOCK-bit slice with outputs sum0, sum1, G, P, instantiated NBLK times via generate.
- Lookahead, select and flags stay in the top level.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, out_ready=1 -> after 2 cycles result=0x80000000, ovf=1, cout=0, ne=1.
- SUB 0x00000005 - 0x00000005 -> result=0, ne=0, cout=1, ltu=0, lt=0; then SUB 0xFFFFFFFF - 0x00000001 -> result=0xFFFFFFFE, lt=1, ltu=0.
- Cross-block carry (WIDTH=64, BLOCK=16):
  - ADD 0xFFFFFFFFFFFFFFFF + 1 -> result=0, cout=1, ovf=0.
  - ADDC 0x0000FFFF + 0 with cin=1 -> 0x00010000.
- Backpressure: issue tags 1..6 back-to-back, hold out_ready=0 for cycles 3-6 -> in_ready=0 once v1=v2=1; outputs stable while stalled; tags emerge 1..6 in order with no loss.
- Reset mid-stream: reset_n low with two ops in flight -> out_valid=0 immediately (asynchronous), all outputs 0; after release the next op returns its own tag only.
- Randomised sweep against a reference model (WIDTH 32/BLOCK 8 and WIDTH 64/BLOCK 16, all 4 ops, random out_ready) -> every result and flag matches the model exactly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined carry-lookahead add/subtract unit.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ADDC = 2'b10,
    OP_SUBB = 2'b11
  } op_e;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic lt;
    logic ltu;
    logic ne;
  } flags_t;

  function automatic int nblk(input int width, input int block);
    return width / block;
  endfunction

endpackage

// File: rtl/cla_block.sv
// One lookahead slice: both speculative sums plus block generate/propagate.
module cla_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] i_a,
  input  logic [BLOCK-1:0] i_b,
  output logic [BLOCK-1:0] o_sum0,
  output logic [BLOCK-1:0] o_sum1,
  output logic             o_g,
  output logic             o_p
);

  logic [BLOCK:0] w_s0;

  // Carry out of the carry-in-0 sum is exactly the block generate.
  assign w_s0   = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum0 = w_s0[BLOCK-1:0];
  assign o_g    = w_s0[BLOCK];
  assign o_sum1 = i_a + i_b + {{(BLOCK-1){1'b0}}, 1'b1};
  assign o_p    = &(i_a ^ i_b);

endmodule

// File: rtl/pipelined_cla_alu.sv
// Two-stage carry-select/lookahead adder-subtractor with valid/ready flow control.
module pipelined_cla_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             lt,
  output logic             ltu,
  output logic             ne,
  output logic [TAG_W-1:0] tag_out
);

  localparam int NBLK = nblk(WIDTH, BLOCK);

  logic                       w_adv1, w_adv2;
  logic [WIDTH-1:0]           w_bp;
  logic                       w_c0;
  logic [NBLK-1:0][BLOCK-1:0] w_sum0, w_sum1;
  logic [NBLK-1:0]            w_g, w_p;

  logic                       r_v1;
  logic [NBLK-1:0][BLOCK-1:0] r_sum0, r_sum1;
  logic [NBLK-1:0]            r_g, r_p;
  logic                       r_c0, r_amsb, r_bmsb;
  logic [TAG_W-1:0]           r_tag1;

  logic [NBLK:0]              w_gc, w_c;
  logic                       w_term;
  logic [NBLK-1:0][BLOCK-1:0] w_sel;
  logic [WIDTH-1:0]           w_res;
  flags_t                     w_flags;

  logic                       r_v2;
  logic [WIDTH-1:0]           r_res;
  flags_t                     r_flags;
  logic [TAG_W-1:0]           r_tag2;

  assign w_adv2   = ~r_v2 | out_ready;
  assign w_adv1   = ~r_v1 | w_adv2;
  assign in_ready = w_adv1;

  assign w_bp = (op_e'(op) == OP_SUB || op_e'(op) == OP_SUBB) ? ~b : b;

  always_comb begin
    case (op_e'(op))
      OP_ADD:  w_c0 = 1'b0;
      OP_SUB:  w_c0 = 1'b1;
      default: w_c0 = cin;
    endcase
  end

  for (genvar i = 0; i < NBLK; i++) begin : g_blk
    cla_block #(.BLOCK(BLOCK)) u_blk (
      .i_a    (a[i*BLOCK +: BLOCK]),
      .i_b    (w_bp[i*BLOCK +: BLOCK]),
      .o_sum0 (w_sum0[i]),
      .o_sum1 (w_sum1[i]),
      .o_g    (w_g[i]),
      .o_p    (w_p[i])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_v1   <= 1'b0;
      r_sum0 <= '0;
      r_sum1 <= '0;
      r_g    <= '0;
      r_p    <= '0;
      r_c0   <= 1'b0;
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
      r_tag1 <= '0;
    end else if (w_adv1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_sum0 <= w_sum0;
        r_sum1 <= w_sum1;
        r_g    <= w_g;
        r_p    <= w_p;
        r_c0   <= w_c0;
        r_amsb <= a[WIDTH-1];
        r_bmsb <= w_bp[WIDTH-1];
        r_tag1 <= tag_in;
      end
    end
  end

  // Bit 0 is the carry-in, bit j is G[j-1]; each block carry is a flat
  // OR of (source & all propagates above it), so no carry ripples.
  assign w_gc = {r_g, r_c0};

  always_comb begin
    w_c    = '0;
    w_term = 1'b0;
    w_c[0] = r_c0;
    for (int i = 0; i < NBLK; i++) begin
      for (int j = 0; j <= i + 1; j++) begin
        w_term = w_gc[j];
        for (int k = j; k <= i; k++) w_term = w_term & r_p[k];
        w_c[i+1] = w_c[i+1] | w_term;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NBLK; i++) w_sel[i] = w_c[i] ? r_sum1[i] : r_sum0[i];
  end

  assign w_res = w_sel;

  always_comb begin
    w_flags.cout = w_c[NBLK];
    w_flags.ovf  = (r_amsb == r_bmsb) & (w_res[WIDTH-1] != r_amsb);
    w_flags.lt   = w_res[WIDTH-1] ^ w_flags.ovf;
    w_flags.ltu  = ~w_c[NBLK];
    w_flags.ne   = |w_res;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_v2    <= 1'b0;
      r_res   <= '0;
      r_flags <= '0;
      r_tag2  <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_res   <= w_res;
        r_flags <= w_flags;
        r_tag2  <= r_tag1;
      end
    end
  end

  assign out_valid = r_v2;
  assign result    = r_res;
  assign cout      = r_flags.cout;
  assign ovf       = r_flags.ovf;
  assign lt        = r_flags.lt;
  assign ltu       = r_flags.ltu;
  assign ne        = r_flags.ne;
  assign tag_out   = r_tag2;

endmodule
